cordic_output_stream: RTL and testbench
=======================================

Name: cordic_output_stream

Overview:
- Registered, parametrised output stage behind the CORDIC iteration pipeline.
- Applies flip correction to x with saturation, then packs the result into one or two bus words.
- Buffers packed results in a small FIFO and presents them downstream over a valid/ready handshake.
- The upstream pipeline cannot stall. When the FIFO is full, results are dropped and recorded in a sticky overflow flag.

Parameters:
- OUTPUT_WIDTH, 16, width of degree/x/y result fields (signed); must be <= BUS_WIDTH.
- BUS_WIDTH, 32, width of interface_out word.
- FIFO_DEPTH, 4, number of results buffered (power of two, >= 2).
- FLIP_FLAG_WIDTH, 1, width of flip flag from core; any nonzero value means flip.
- Derived BEATS = 1 if 2*OUTPUT_WIDTH <= BUS_WIDTH, else 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- degree_out  in  OUTPUT_WIDTH  signed angle result from core.
- x_out  in  OUTPUT_WIDTH  signed x result.
- y_out  in  OUTPUT_WIDTH  signed y result.
- flip_out  in  FLIP_FLAG_WIDTH  quadrant flip flag.
- arctan_en_out  in  1  1 = arctan/vectoring result, 0 = rotation result.
- valid_out  in  1  result qualifier, one cycle per result.
- ready_in  in  1  downstream accepts current word.
- clear_overflow  in  1  synchronous clear of overflow flag.
- interface_out  out  BUS_WIDTH  packed output word.
- valid_out_interface  out  1  interface_out valid.
- last_out  out  1  final word of current result.
- arctan_flag_out  out  1  current word belongs to an arctan result.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  results held, including the one being presented.
- overflow  out  1  sticky: a result was dropped.

Behaviour:
- Reset (async, active-high): FIFO empty; fifo_count=0; valid_out_interface=0; last_out=0; arctan_flag_out=0; interface_out=0; overflow=0; beat index=0. Reset mid-transfer discards all stored results and any partial beat.
- Post-processing (combinational, before FIFO write):
  - xc = flip ? -x_out : x_out.
  - -(-2^(OUTPUT_WIDTH-1)) saturates to 2^(OUTPUT_WIDTH-1)-1.
  - y and degree pass unchanged.
- Word packing, BEATS=1:
  - arctan: word = sign-extended degree in [OUTPUT_WIDTH-1:0]; all remaining bits 0.
  - rotation: word = {zero pad, y, xc}. y occupies [2W-1:W], xc occupies [W-1:0]; pad bits 0.
- Word packing, BEATS=2:
  - arctan: single word, degree sign-extended to BUS_WIDTH, last_out=1.
  - rotation: beat 0 = xc sign-extended (last_out=0); beat 1 = y sign-extended (last_out=1).
- FIFO stores one entry per result: degree, xc, y, arctan flag.
- Push: when valid_out=1 and (count<FIFO_DEPTH, or a final-beat pop occurs the same cycle).
- Drop: if valid_out=1, count==FIFO_DEPTH and no final-beat pop this edge, the result is discarded and overflow is set.
- Latency: result captured at edge N appears on interface_out with valid_out_interface=1 after edge N (earliest visible in cycle N+1). Zero-bubble throughput when ready_in is held at 1.
- Handshake:
  - A word transfers on an edge where valid_out_interface && ready_in.
  - While valid_out_interface=1 and ready_in=0, interface_out, last_out and arctan_flag_out hold stable.
  - valid_out_interface never deasserts without a transfer.
- Beat sequencing: beat index advances 0->1 on a non-last transfer. On a last transfer it returns to 0 and the entry pops.
- fifo_count decrements only on pop (last beat) and increments on push; simultaneous push and pop leaves it unchanged.
- overflow:
  - Set on drop; clears on clear_overflow=1.
  - If a drop and clear_overflow occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by fifo_count.

Test Plan:
- W=16, BUS=32, ready_in=1: rotation x=0x0100, y=0xFF80, flip=0 -> one cycle later interface_out=0xFF800100, valid=1, last=1, arctan_flag=0.
- Flip with saturation: x=0x8000, y=0x0001, flip=1 -> interface_out=0x00017FFF; x=0x0100, flip=1 -> low half 0xFF00.
- Arctan: degree=0xF000, arctan_en=1 -> interface_out=0x0000F000 (BUS=32, W=16: upper bits 0), arctan_flag=1.
- Backpressure/overflow: ready_in=0; 6 consecutive valid results with FIFO_DEPTH=4 -> fifo_count reaches 4, overflow=1. Raise ready_in -> the first 4 results come out in order, then valid drops. Pulse clear_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full, ready_in=1 and valid_out=1 on the same edge -> result accepted, count stays 4, overflow stays 0.
- W=24, BUS=32 (BEATS=2): rotation x=0x000010, y=0xFFFFF0 -> beat 0 = 0x00000010 (last=0), beat 1 = 0xFFFFFFF0 (last=1). Assert rst between beats -> valid=0 immediately, count=0.

Source files
------------

// File: rtl/cordic_output_stream_if.sv
// Downstream word stream of the CORDIC output stage.
// master drives word/valid/last/arctan flag, slave drives ready_in.
interface cordic_output_stream_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] interface_out;
  logic                 valid_out_interface;
  logic                 last_out;
  logic                 arctan_flag_out;
  logic                 ready_in;

  modport master (
    output interface_out,
    output valid_out_interface,
    output last_out,
    output arctan_flag_out,
    input  ready_in
  );

  modport slave (
    input  interface_out,
    input  valid_out_interface,
    input  last_out,
    input  arctan_flag_out,
    output ready_in
  );
endinterface

// File: rtl/cordic_output_stream.sv
// CORDIC output stage: flip correction with saturation, FIFO buffering
// and one/two-beat packing onto a valid/ready word stream.
// Ports: clk, rst (async high); degree_out/x_out/y_out/flip_out/
// arctan_en_out/valid_out from core; clear_overflow; bus (master);
// fifo_count and sticky overflow status.
module cordic_output_stream #(
  parameter int OUTPUT_WIDTH    = 16,
  parameter int BUS_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int FLIP_FLAG_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [OUTPUT_WIDTH-1:0]    degree_out,
  input  logic signed [OUTPUT_WIDTH-1:0]    x_out,
  input  logic signed [OUTPUT_WIDTH-1:0]    y_out,
  input  logic [FLIP_FLAG_WIDTH-1:0]        flip_out,
  input  logic                              arctan_en_out,
  input  logic                              valid_out,
  input  logic                              clear_overflow,
  cordic_output_stream_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow
);

  localparam int W     = OUTPUT_WIDTH;
  localparam int BEATS = (2 * W <= BUS_WIDTH) ? 1 : 2;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [W-1:0]  MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_V = ~MIN_V;
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);

  logic [W-1:0]    r_deg [FIFO_DEPTH];
  logic [W-1:0]    r_x   [FIFO_DEPTH];
  logic [W-1:0]    r_y   [FIFO_DEPTH];
  logic            r_at  [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_beat;
  logic            r_ovf;

  logic [W-1:0]         w_xc;
  logic [W-1:0]         w_h_deg;
  logic [W-1:0]         w_h_x;
  logic [W-1:0]         w_h_y;
  logic                 w_h_at;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [BUS_WIDTH-1:0] w_word;

  // Negating the most negative value has no representation; clamp it.
  always_comb begin
    w_xc = x_out;
    if (|flip_out) begin
      if (x_out == MIN_V) w_xc = MAX_V;
      else                w_xc = W'(0) - x_out;
    end
  end

  assign w_h_deg = r_deg[r_rptr];
  assign w_h_x   = r_x[r_rptr];
  assign w_h_y   = r_y[r_rptr];
  assign w_h_at  = r_at[r_rptr];

  assign w_valid = (r_count != '0);
  assign w_last  = w_h_at | (BEATS == 1) | r_beat;
  assign w_xfer  = w_valid & bus.ready_in;
  assign w_pop   = w_xfer & w_last;
  // A final-beat pop frees a slot on the same edge.
  assign w_push  = valid_out & ((r_count != FULL) | w_pop);
  assign w_drop  = valid_out & ~w_push;

  always_comb begin
    w_word = '0;
    if (BEATS == 1) begin
      if (w_h_at) w_word = BUS_WIDTH'(w_h_deg);
      else        w_word = BUS_WIDTH'({w_h_y, w_h_x});
    end else begin
      if (w_h_at)      w_word = BUS_WIDTH'(signed'(w_h_deg));
      else if (r_beat) w_word = BUS_WIDTH'(signed'(w_h_y));
      else             w_word = BUS_WIDTH'(signed'(w_h_x));
    end
    if (!w_valid) w_word = '0;
  end

  assign bus.interface_out       = w_word;
  assign bus.valid_out_interface = w_valid;
  assign bus.last_out            = w_valid & w_last;
  assign bus.arctan_flag_out     = w_valid & w_h_at;
  assign fifo_count              = r_count;
  assign overflow                = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_deg[r_wptr] <= degree_out;
      r_x[r_wptr]   <= w_xc;
      r_y[r_wptr]   <= y_out;
      r_at[r_wptr]  <= arctan_en_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_beat  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_xfer) r_beat <= ~w_last;
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_output_stream.sv
// Scoreboard bench for cordic_output_stream: one-beat (W=16)
// and two-beat (W=24) instances on a shared clock and reset.
module tb_cordic_output_stream;

  typedef struct {
    logic [31:0] w;
    logic        last;
    logic        at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_deg, a_x, a_y;
  logic        a_flip, a_at, a_vin, a_clr;
  logic [2:0]  a_cnt;
  logic        a_ovf;
  logic [23:0] b_deg, b_x, b_y;
  logic        b_flip, b_at, b_vin, b_clr;
  logic [2:0]  b_cnt;
  logic        b_ovf;

  cordic_output_stream_if #(.BUS_WIDTH(32)) if_a ();
  cordic_output_stream_if #(.BUS_WIDTH(32)) if_b ();

  cordic_output_stream #(
    .OUTPUT_WIDTH(16), .BUS_WIDTH(32),
    .FIFO_DEPTH(4), .FLIP_FLAG_WIDTH(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .degree_out(a_deg), .x_out(a_x), .y_out(a_y),
    .flip_out(a_flip), .arctan_en_out(a_at),
    .valid_out(a_vin), .clear_overflow(a_clr),
    .bus(if_a), .fifo_count(a_cnt), .overflow(a_ovf)
  );

  cordic_output_stream #(
    .OUTPUT_WIDTH(24), .BUS_WIDTH(32),
    .FIFO_DEPTH(4), .FLIP_FLAG_WIDTH(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .degree_out(b_deg), .x_out(b_x), .y_out(b_y),
    .flip_out(b_flip), .arctan_en_out(b_at),
    .valid_out(b_vin), .clear_overflow(b_clr),
    .bus(if_b), .fifo_count(b_cnt), .overflow(b_ovf)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [15:0] xc16(logic [15:0] x, logic f);
    if (!f) return x;
    if (x == 16'h8000) return 16'h7fff;
    return 16'h0000 - x;
  endfunction

  function automatic logic [23:0] xc24(logic [23:0] x, logic f);
    if (!f) return x;
    if (x == 24'h800000) return 24'h7fffff;
    return 24'h000000 - x;
  endfunction

  task automatic drive_a(input logic [15:0] d, x, y,
                         input logic f, at, keep);
    exp_t e;
    a_deg = d; a_x = x; a_y = y;
    a_flip = f; a_at = at; a_vin = 1'b1;
    e.last = 1'b1;
    e.at   = at;
    e.w    = at ? {16'h0000, d} : {y, xc16(x, f)};
    if (keep) qa.push_back(e);
  endtask

  task automatic drive_b(input logic [23:0] d, x, y,
                         input logic f, at);
    exp_t e;
    logic [23:0] xc;
    b_deg = d; b_x = x; b_y = y;
    b_flip = f; b_at = at; b_vin = 1'b1;
    xc = xc24(x, f);
    e.at = at;
    if (at) begin
      e.w = {{8{d[23]}}, d}; e.last = 1'b1;
      qb.push_back(e);
    end else begin
      e.w = {{8{xc[23]}}, xc}; e.last = 1'b0;
      qb.push_back(e);
      e.w = {{8{y[23]}}, y}; e.last = 1'b1;
      qb.push_back(e);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (if_a.valid_out_interface !== 1'b0 || a_cnt !== 3'd0 ||
        a_ovf !== 1'b0 || if_a.interface_out !== 32'h0 ||
        if_a.last_out !== 1'b0 || if_a.arctan_flag_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: v=%b cnt=%0d ovf=%b w=%h l=%b at=%b req all 0",
        if_a.valid_out_interface, a_cnt, a_ovf,
        if_a.interface_out, if_a.last_out, if_a.arctan_flag_out);
    end
    checks++;
    if (if_b.valid_out_interface !== 1'b0 || b_cnt !== 3'd0 ||
        b_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: v=%b cnt=%0d ovf=%b req 0",
        if_b.valid_out_interface, b_cnt, b_ovf);
    end
  endtask

  // Back-to-back results with ready held high: no bubbles expected.
  task automatic test_stream;
    exp_t e;
    int   seen = 0;
    if_a.ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (if_a.valid_out_interface === 1'b1) begin
        seen++;
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: w=%h req none", if_a.interface_out);
        end else begin
          e = qa.pop_front();
          if (if_a.interface_out !== e.w || if_a.last_out !== e.last ||
              if_a.arctan_flag_out !== e.at) begin
            failures++;
            $display("FAIL stream_word: w=%h l=%b at=%b req w=%h l=%b at=%b",
              if_a.interface_out, if_a.last_out, if_a.arctan_flag_out,
              e.w, e.last, e.at);
          end
        end
      end
      a_vin = 1'b0;
      case (i)
        0: drive_a(16'h0, 16'h0100, 16'hff80, 1'b0, 1'b0, 1'b1);
        1: drive_a(16'h0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        2: drive_a(16'h0, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1);
        3: drive_a(16'hf000, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1);
        4: drive_a(16'h0, 16'h7fff, 16'h8000, 1'b1, 1'b0, 1'b1);
        default: ;
      endcase
      if (i == 2) begin
        checks++;
        if (seen != 2) begin
          failures++;
          $display("FAIL stream_latency: seen=%0d req 2", seen);
        end
      end
    end
    checks++;
    if (qa.size() != 0 || if_a.valid_out_interface !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: left=%0d v=%b req 0 0",
        qa.size(), if_a.valid_out_interface);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    if_a.ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_a(16'h0, 16'(16'h0010 + i), 16'(16'h0200 + i),
              1'b0, 1'b0, i < 4);
    end
    @(negedge clk);
    a_vin = 1'b0;
    checks++;
    if (a_cnt !== 3'd4 || a_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full: cnt=%0d ovf=%b req 4 1", a_cnt, a_ovf);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if_a.valid_out_interface !== 1'b1 ||
          if_a.interface_out !== qa[0].w) begin
        failures++;
        $display("FAIL ovf_hold: v=%b w=%h req 1 %h",
          if_a.valid_out_interface, if_a.interface_out, qa[0].w);
      end
    end
    if_a.ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (if_a.valid_out_interface === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL ovf_extra: w=%h req none", if_a.interface_out);
        end else begin
          e = qa.pop_front();
          if (if_a.interface_out !== e.w || if_a.last_out !== e.last) begin
            failures++;
            $display("FAIL ovf_order: w=%h l=%b req %h %b",
              if_a.interface_out, if_a.last_out, e.w, e.last);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (qa.size() != 0 || if_a.valid_out_interface !== 1'b0 ||
        a_cnt !== 3'd0 || a_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after: left=%0d v=%b cnt=%0d ovf=%b req 0 0 0 1",
        qa.size(), if_a.valid_out_interface, a_cnt, a_ovf);
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    checks++;
    if (a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b req 0", a_ovf);
    end
  endtask

  // Full FIFO, pop and push on the same edge: nothing dropped.
  task automatic test_full_pop;
    exp_t e;
    if_a.ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_a(16'h0, 16'(16'h0300 + i), 16'h0042, 1'b1, 1'b0, 1'b1);
    end
    @(negedge clk);
    if_a.ready_in = 1'b1;
    drive_a(16'h1111, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (if_a.valid_out_interface === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL fp_extra: w=%h req none", if_a.interface_out);
        end else begin
          e = qa.pop_front();
          if (if_a.interface_out !== e.w || if_a.arctan_flag_out !== e.at) begin
            failures++;
            $display("FAIL fp_word: w=%h at=%b req %h %b",
              if_a.interface_out, if_a.arctan_flag_out, e.w, e.at);
          end
        end
      end
      @(negedge clk);
      a_vin = 1'b0;
      if (i == 0) begin
        checks++;
        if (a_cnt !== 3'd4 || a_ovf !== 1'b0) begin
          failures++;
          $display("FAIL fp_count: cnt=%0d ovf=%b req 4 0", a_cnt, a_ovf);
        end
      end
    end
    checks++;
    if (qa.size() != 0 || a_cnt !== 3'd0) begin
      failures++;
      $display("FAIL fp_drain: left=%0d cnt=%0d req 0 0", qa.size(), a_cnt);
    end
  endtask

  task automatic test_two_beat;
    exp_t e;
    if_b.ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_b.valid_out_interface === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL beat_extra: w=%h req none", if_b.interface_out);
        end else begin
          e = qb.pop_front();
          if (if_b.interface_out !== e.w || if_b.last_out !== e.last ||
              if_b.arctan_flag_out !== e.at) begin
            failures++;
            $display("FAIL beat_word: w=%h l=%b at=%b req w=%h l=%b at=%b",
              if_b.interface_out, if_b.last_out, if_b.arctan_flag_out,
              e.w, e.last, e.at);
          end
        end
      end
      b_vin = 1'b0;
      case (i)
        0: drive_b(24'h0, 24'h000010, 24'hfffff0, 1'b0, 1'b0);
        1: drive_b(24'hfff000, 24'h0, 24'h0, 1'b0, 1'b1);
        2: drive_b(24'h0, 24'h800000, 24'h000005, 1'b1, 1'b0);
        default: ;
      endcase
    end
    checks++;
    if (qb.size() != 0 || if_b.valid_out_interface !== 1'b0 ||
        b_cnt !== 3'd0) begin
      failures++;
      $display("FAIL beat_drain: left=%0d v=%b cnt=%0d req 0 0 0",
        qb.size(), if_b.valid_out_interface, b_cnt);
    end
  endtask

  task automatic test_reset_mid;
    if_b.ready_in = 1'b0;
    @(negedge clk);
    drive_b(24'h0, 24'h000010, 24'hfffff0, 1'b0, 1'b0);
    @(negedge clk);
    b_vin = 1'b0;
    if_b.ready_in = 1'b1;
    @(negedge clk);
    if_b.ready_in = 1'b0;
    void'(qb.pop_front());
    checks++;
    if (if_b.valid_out_interface !== 1'b1 ||
        if_b.interface_out !== qb[0].w || if_b.last_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_beat1: v=%b w=%h l=%b req 1 %h 1",
        if_b.valid_out_interface, if_b.interface_out,
        if_b.last_out, qb[0].w);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (if_b.valid_out_interface !== 1'b0 || b_cnt !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset: v=%b cnt=%0d req 0 0",
        if_b.valid_out_interface, b_cnt);
    end
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    if_b.ready_in = 1'b1;
    @(negedge clk);
    drive_b(24'h0, 24'h000001, 24'h000002, 1'b0, 1'b0);
    @(negedge clk);
    b_vin = 1'b0;
    checks++;
    if (if_b.interface_out !== 32'h1 || if_b.last_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart: w=%h l=%b req 00000001 0",
        if_b.interface_out, if_b.last_out);
    end
    @(negedge clk);
    @(negedge clk);
    qb.delete();
  endtask

  initial begin
    a_deg = '0; a_x = '0; a_y = '0;
    a_flip = 1'b0; a_at = 1'b0; a_vin = 1'b0; a_clr = 1'b0;
    b_deg = '0; b_x = '0; b_y = '0;
    b_flip = 1'b0; b_at = 1'b0; b_vin = 1'b0; b_clr = 1'b0;
    if_a.ready_in = 1'b0;
    if_b.ready_in = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_stream;
    test_overflow;
    test_full_pop;
    test_two_beat;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
